// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, with a registered borrow.
// Computes a - b mod 2^WIDTH and flags a < b once the last bit has been processed.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;

  logic             d_bit_c;
  logic             br_nxt_c;
  logic             last_c;
  logic [WIDTH-1:0] res_nxt_c;

  // Full-subtractor cell on the current LSBs, plus the result after this bit is shifted in.
  always_comb begin
    d_bit_c   = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt_c  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    last_c    = (cnt == CW'(WIDTH - 1));
    res_nxt_c = {d_bit_c, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      br         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt_c;
          res  <= res_nxt_c;
          cnt  <= cnt + CW'(1);
          // Outputs only change once the whole word is done; partial results stay internal.
          if (last_c) begin
            diff       <= res_nxt_c;
            borrow_out <= br_nxt_c;
            state      <= DONE;
            done       <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): known vectors, start masking,
// mid-operation reset and a long back-to-back run against a reference subtraction.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int errors;
  int checks;
  int done_cnt;
  int cyc;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: launch one operation and report latency (edges after accept) and outputs.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [7:0] d, output logic bo);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    d  = diff;
    bo = borrow_out;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b, want all 0",
               busy, done, diff, borrow_out);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'h35, 8'h12, 8'h00, 8'hFF, 8'h80};
    logic [7:0] vb [5] = '{8'h12, 8'h35, 8'h01, 8'hFF, 8'h7F};
    logic [7:0] ed [5] = '{8'h23, 8'hDD, 8'hFF, 8'h00, 8'h01};
    logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [7:0] d;
    logic bo;
    for (int k = 0; k < 5; k++) begin
      run_op(va[k], vb[k], lat, d, bo);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d, want 8", k, lat);
      end
      checks++;
      if (d !== ed[k] || bo !== eb[k]) begin
        errors++;
        $display("FAIL vec%0d_result: got %h/%b, want %h/%b", k, d, bo, ed[k], eb[k]);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_pulse: got done=%b busy=%b, want 0/0", k, done, busy);
      end
    end
  endtask

  task automatic test_idle_hold();
    a = 8'h11;
    b = 8'h99;
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (diff !== 8'h01 || borrow_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got diff=%h bo=%b busy=%b done=%b, want 01/0/0/0",
               diff, borrow_out, busy, done);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int d0;
    d0 = done_cnt;
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || diff !== 8'h01) begin
      errors++;
      $display("FAIL run_busy_stable: got busy=%b diff=%h, want 1/01", busy, diff);
    end
    tick(); tick(); tick();
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    lat = 99;
    for (int i = 4; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== 8 || diff !== 8'h23 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d %h/%b, want 8 23/0", lat, diff, borrow_out);
    end
    repeat (6) tick();
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_single: got pulses=%0d busy=%b, want 1/0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0;
    int lat;
    logic [7:0] d;
    logic bo;
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b diff=%h bo=%b, want all 0",
               busy, done, diff, borrow_out);
    end
    repeat (3) tick();
    #2;
    rst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got pulses=%0d busy=%b, want 0/0", done_cnt - d0, busy);
    end
    run_op(8'h35, 8'h12, lat, d, bo);
    checks++;
    if (lat !== 8 || d !== 8'h23 || bo !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart: got lat=%0d %h/%b, want 8 23/0", lat, d, bo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] ed;
    int last;
    bit seen;
    last = 0;
    ea = 8'($urandom);
    eb = 8'($urandom);
    a = ea;
    b = eb;
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL b2b_timeout: op %0d never completed", k);
        break;
      end
      ed = ea - eb;
      checks++;
      if (diff !== ed || borrow_out !== (ea < eb)) begin
        errors++;
        $display("FAIL b2b_result: op %0d a=%h b=%h got %h/%b, want %h/%b",
                 k, ea, eb, diff, borrow_out, ed, ea < eb);
      end
      if (k > 0) begin
        checks++;
        if (cyc - last !== 10) begin
          errors++;
          $display("FAIL b2b_spacing: op %0d got %0d cycles, want 10", k, cyc - last);
        end
      end
      last = cyc;
      ea = 8'($urandom);
      eb = 8'($urandom);
      a = ea;
      b = eb;
    end
    start = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    done_cnt = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_vectors();
    test_idle_hold();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
